// File: rtl/mskxor_acc_if.sv
// Handshake bundle for the masked XOR accumulator: input beat stream and result stream.
interface mskxor_acc_if #(
  parameter int unsigned W = 2
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mskxor_acc.sv
// Share-wise XOR accumulator: folds up to BEATS masked words per frame into one
// registered masked word and offers it on a valid/ready output.
module mskxor_acc #(
  parameter int unsigned d     = 2,
  parameter int unsigned count = 1,
  parameter int unsigned BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  mskxor_acc_if.slave  bus
);

  localparam int unsigned W     = count * d;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  state_t           first_state_c;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ready_c;
  logic             xfer_c;

  // A finished frame blocks new beats until it drains; draining frees the slot in the same edge.
  assign ready_c       = (state != DONE) || bus.out_ready;
  assign xfer_c        = bus.in_valid && ready_c;
  assign first_state_c = (bus.in_last || (BEATS == 1)) ? DONE : ACC;

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (xfer_c) begin
          acc_nxt   = bus.in_data;
          cnt_nxt   = CNT_W'(1);
          state_nxt = first_state_c;
        end
      end
      ACC: begin
        if (xfer_c) begin
          acc_nxt   = acc ^ bus.in_data;
          cnt_nxt   = cnt + CNT_W'(1);
          state_nxt = (bus.in_last || (cnt_nxt == CNT_W'(BEATS))) ? DONE : ACC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          if (xfer_c) begin
            acc_nxt   = bus.in_data;
            cnt_nxt   = CNT_W'(1);
            state_nxt = first_state_c;
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mskxor_acc.sv
// Bench for mskxor_acc: directed frames on BEATS=3 and BEATS=1 instances plus a
// randomized handshake run against a frame-level XOR model.
module tb_mskxor_acc;

  localparam int unsigned D       = 2;
  localparam int unsigned CNT     = 4;
  localparam int unsigned W       = D * CNT;
  localparam int          A_BEATS = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mskxor_acc_if #(.W(W)) a_if ();
  mskxor_acc_if #(.W(W)) b_if ();

  mskxor_acc #(.d(D), .count(CNT), .BEATS(3)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  mskxor_acc #(.d(D), .count(CNT), .BEATS(1)) u_b (.clk(clk), .rst(rst), .bus(b_if));

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level model of the BEATS=3 instance: running XOR of the open frame and one pending result.
  logic           m_pend;
  logic [W-1:0]   m_pend_data;
  logic [CNT-1:0] m_pend_rec;
  logic [W-1:0]   m_cur;
  logic [CNT-1:0] m_cur_rec;
  int             m_cnt;

  function automatic logic [CNT-1:0] recombine(input logic [W-1:0] v);
    logic [CNT-1:0] r;
    r = '0;
    for (int b = 0; b < int'(CNT); b++)
      for (int s = 0; s < int'(D); s++)
        r[b] = r[b] ^ v[b*D+s];
    return r;
  endfunction

  task automatic drive_a(input logic v, input logic [W-1:0] dat, input logic l, input logic ordy);
    @(negedge clk);
    a_if.in_valid  = v;
    a_if.in_data   = dat;
    a_if.in_last   = l;
    a_if.out_ready = ordy;
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [W-1:0] dat, input logic l, input logic ordy);
    @(negedge clk);
    b_if.in_valid  = v;
    b_if.in_data   = dat;
    b_if.in_last   = l;
    b_if.out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_last = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_last = 1'b0; b_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (a_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_out_valid: got %b want 0", a_if.out_valid); end
    n_tests++; if (a_if.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_a_out_data: got %h want 00", a_if.out_data); end
    n_tests++; if (a_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_in_ready: got %b want 1", a_if.in_ready); end
    n_tests++; if (b_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_out_valid: got %b want 0", b_if.out_valid); end
    n_tests++; if (b_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_in_ready: got %b want 1", b_if.in_ready); end
  endtask

  task automatic test_beats_cap();
    logic [W-1:0] words [3];
    logic [W-1:0] exp;
    words[0] = 8'h0F; words[1] = 8'h33; words[2] = 8'h55;
    exp = '0;
    for (int i = 0; i < 3; i++) begin
      exp = exp ^ words[i];
      drive_a(1'b1, words[i], 1'b0, 1'b0);
      n_tests++; if (a_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL cap_in_ready_beat%0d: got %b want 1", i, a_if.in_ready); end
      n_tests++; if (a_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL cap_out_valid_beat%0d: got %b want 0", i, a_if.out_valid); end
    end
    drive_a(1'b0, '0, 1'b0, 1'b0);
    n_tests++; if (a_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL cap_out_valid: got %b want 1", a_if.out_valid); end
    n_tests++; if (a_if.out_data !== exp) begin n_fail++; $display("FAIL cap_out_data: got %h want %h", a_if.out_data, exp); end
    n_tests++; if (a_if.out_data !== 8'h69) begin n_fail++; $display("FAIL cap_out_data_const: got %h want 69", a_if.out_data); end
    n_tests++; if (a_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL cap_in_ready_done: got %b want 0", a_if.in_ready); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, 8'hEE, 1'b1, 1'b0);
      n_tests++; if (a_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_%0d: got %b want 1", i, a_if.out_valid); end
      n_tests++; if (a_if.out_data !== 8'h69) begin n_fail++; $display("FAIL bp_out_data_%0d: got %h want 69", i, a_if.out_data); end
      n_tests++; if (a_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, a_if.in_ready); end
    end
    drive_a(1'b0, '0, 1'b0, 1'b1);
    n_tests++; if (a_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", a_if.in_ready); end
    n_tests++; if (a_if.out_data !== 8'h69) begin n_fail++; $display("FAIL bp_release_out_data: got %h want 69", a_if.out_data); end
    drive_a(1'b0, '0, 1'b0, 1'b1);
    n_tests++; if (a_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained_out_valid: got %b want 0", a_if.out_valid); end
  endtask

  task automatic test_early_last();
    logic [W-1:0] exp;
    exp = 8'hA5 ^ 8'h5A;
    drive_a(1'b1, 8'hA5, 1'b0, 1'b0);
    drive_a(1'b1, 8'h5A, 1'b1, 1'b0);
    drive_a(1'b0, '0, 1'b0, 1'b0);
    n_tests++; if (a_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL early_out_valid: got %b want 1", a_if.out_valid); end
    n_tests++; if (a_if.out_data !== exp) begin n_fail++; $display("FAIL early_out_data: got %h want %h", a_if.out_data, exp); end
  endtask

  task automatic test_overlap();
    logic [W-1:0] exp;
    exp = 8'h11 ^ 8'h22;
    drive_a(1'b1, 8'h11, 1'b0, 1'b1);
    n_tests++; if (a_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL ovl_in_ready: got %b want 1", a_if.in_ready); end
    n_tests++; if (a_if.out_data !== 8'hFF) begin n_fail++; $display("FAIL ovl_old_data: got %h want ff", a_if.out_data); end
    drive_a(1'b1, 8'h22, 1'b1, 1'b1);
    n_tests++; if (a_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovl_mid_out_valid: got %b want 0", a_if.out_valid); end
    drive_a(1'b0, '0, 1'b0, 1'b1);
    n_tests++; if (a_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL ovl_out_valid: got %b want 1", a_if.out_valid); end
    n_tests++; if (a_if.out_data !== exp) begin n_fail++; $display("FAIL ovl_out_data: got %h want %h", a_if.out_data, exp); end
    drive_a(1'b0, '0, 1'b0, 1'b1);
    n_tests++; if (a_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovl_drained: got %b want 0", a_if.out_valid); end
  endtask

  task automatic test_stream_beats1();
    logic [W-1:0] words [3];
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive_b(1'b1, words[i], 1'b0, 1'b1);
      else       drive_b(1'b0, '0, 1'b0, 1'b1);
      n_tests++; if (b_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL b1_in_ready_%0d: got %b want 1", i, b_if.in_ready); end
      if (i > 0) begin
        n_tests++; if (b_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL b1_out_valid_%0d: got %b want 1", i, b_if.out_valid); end
        n_tests++; if (b_if.out_data !== words[i-1]) begin n_fail++; $display("FAIL b1_out_data_%0d: got %h want %h", i, b_if.out_data, words[i-1]); end
      end
    end
    drive_b(1'b0, '0, 1'b0, 1'b1);
    n_tests++; if (b_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL b1_drained: got %b want 0", b_if.out_valid); end
  endtask

  task automatic test_reset_midframe();
    drive_a(1'b1, 8'h0F, 1'b0, 1'b1);
    drive_a(1'b1, 8'h33, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    a_if.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (a_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", a_if.out_valid); end
    n_tests++; if (a_if.out_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_out_data: got %h want 00", a_if.out_data); end
    n_tests++; if (a_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", a_if.in_ready); end
    drive_a(1'b1, 8'h0F, 1'b0, 1'b0);
    drive_a(1'b1, 8'h33, 1'b0, 1'b0);
    drive_a(1'b1, 8'h55, 1'b0, 1'b0);
    n_tests++; if (a_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_early_valid: got %b want 0", a_if.out_valid); end
    drive_a(1'b0, '0, 1'b0, 1'b1);
    n_tests++; if (a_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_valid: got %b want 1", a_if.out_valid); end
    n_tests++; if (a_if.out_data !== 8'h69) begin n_fail++; $display("FAIL rstmid_new_data: got %h want 69", a_if.out_data); end
    drive_a(1'b0, '0, 1'b0, 1'b1);
    n_tests++; if (a_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_drained: got %b want 0", a_if.out_valid); end
  endtask

  task automatic test_random();
    logic         v;
    logic         l;
    logic         ordy;
    logic [W-1:0] dat;
    logic         exp_ready;
    m_pend = 1'b0; m_pend_data = '0; m_pend_rec = '0;
    m_cur = '0; m_cur_rec = '0; m_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc < 390) begin
        v    = 1'($urandom_range(0, 1));
        l    = ($urandom_range(0, 2) == 0);
        ordy = ($urandom_range(0, 3) != 0);
      end else begin
        v = 1'b0; l = 1'b0; ordy = 1'b1;
      end
      dat = W'($urandom);
      drive_a(v, dat, l, ordy);
      exp_ready = !m_pend || ordy;
      n_tests++; if (a_if.in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b want %b", cyc, a_if.in_ready, exp_ready); end
      n_tests++; if (a_if.out_valid !== m_pend) begin n_fail++; $display("FAIL rnd_out_valid@%0d: got %b want %b", cyc, a_if.out_valid, m_pend); end
      if (m_pend) begin
        n_tests++; if (a_if.out_data !== m_pend_data) begin n_fail++; $display("FAIL rnd_out_data@%0d: got %h want %h", cyc, a_if.out_data, m_pend_data); end
        n_tests++; if (recombine(a_if.out_data) !== m_pend_rec) begin n_fail++; $display("FAIL rnd_recombined@%0d: got %h want %h", cyc, recombine(a_if.out_data), m_pend_rec); end
      end
      if (m_pend && ordy) m_pend = 1'b0;
      if (v && exp_ready) begin
        m_cur     = ((m_cnt == 0) ? '0 : m_cur) ^ dat;
        m_cur_rec = ((m_cnt == 0) ? '0 : m_cur_rec) ^ recombine(dat);
        m_cnt++;
        if (l || (m_cnt == A_BEATS)) begin
          m_pend      = 1'b1;
          m_pend_data = m_cur;
          m_pend_rec  = m_cur_rec;
          m_cnt       = 0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_beats_cap();
    test_backpressure();
    test_early_last();
    test_overlap();
    test_stream_beats1();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mskxor_acc.md
Name: mskxor_acc

Overview:
- Sequential, parametrised successor of the combinational share-wise masked XOR.
- Accumulates a frame of up to BEATS masked words (count bits, d shares each) by share-wise XOR into a registered d-share accumulator, then presents the result through a valid/ready handshake.
- Share-wise XOR is affine, so no randomness and no refresh are needed.
- Sits between masked datapath stages, e.g. absorbing several masked blocks into one masked state word, or folding partial masked results.

Parameters:
- d, 2, number of shares (masking order + 1); d >= 1.
- count, 1, number of masked bits per word; bus width is count*d.
- BEATS, 4, maximum number of words per frame; BEATS >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  count*d  masked input word, same share layout as all masked buses.
- in_valid  input  1  in_data is valid.
- in_last  input  1  the current beat is the final beat of the frame; qualified by in_valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  count*d  masked accumulated word.
- out_valid  output  1  out_data holds a completed frame.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). While rst=1 at a clock edge: state returns to IDLE, beat counter is cleared to 0, accumulator is cleared to 0, out_valid=0. Reset mid-frame discards the partial frame with no output.
- Output reset values: out_valid=0, out_data=0, in_ready=1 in the first cycle after reset is released.
- Beat transfer: occurs on a clock edge where in_valid && in_ready.
- State IDLE (no frame open):
  - in_ready=1, out_valid=0.
  - On transfer: acc <= in_data (load, not XOR), cnt <= 1.
  - If in_last=1 or BEATS==1, go to DONE; otherwise go to ACC.
- State ACC (frame open):
  - in_ready=1, out_valid=0.
  - On transfer: acc <= acc ^ in_data, bit-for-bit across all count*d bits, so share s of bit b combines only with share s of bit b. cnt <= cnt+1.
  - Go to DONE when in_last=1 or cnt+1==BEATS; BEATS caps the frame even if in_last is never asserted.
  - No transfer: hold state, acc and cnt.
- State DONE:
  - out_valid=1, out_data=acc.
  - out_data is stable while out_valid && !out_ready.
  - in_ready = out_ready. A new frame's first beat is accepted only in the cycle the result drains.
  - out_valid && out_ready with no transfer: go to IDLE.
  - out_valid && out_ready with a transfer: the transfer loads acc as a first beat, cnt <= 1, and the next state follows the IDLE rules (DONE if in_last or BEATS==1, else ACC).
- Latency and throughput:
  - out_valid rises in the cycle after the last beat is accepted.
  - With BEATS=1 and out_ready held at 1, one frame completes every cycle.
- Registers: out_data is driven directly from the acc register; there is no combinational path from in_data to out_data.
- Counter: width is clog2(BEATS+1) and it never wraps. A frame always ends at BEATS beats.
- in_last with in_valid=0 is ignored. in_data is don't-care while in_valid=0.

Test Plan:
- d=2, count=4, BEATS=3. Send 8'h0F, 8'h33, 8'h55 with in_last=0 throughout -> frame closes at beat 3; out_valid rises 1 cycle after beat 3 with out_data=8'h69; in_ready stays 1 until DONE.
- Same configuration. Send 8'hA5, then 8'h5A with in_last=1 -> early close; out_data=8'hFF after 2 beats.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data stays constant at 8'h69, in_ready=0, extra inputs are not accepted; raise out_ready -> one drain, then IDLE.
- Overlap: in DONE, drive out_ready=1 together with in_valid=1, in_data=8'h11 -> the old result drains and the new frame loads acc=8'h11 in the same edge; the next frame result is correct.
- BEATS=1, out_ready=1, stream 8'h01, 8'h02, 8'h03 on consecutive cycles -> out_data 8'h01, 8'h02, 8'h03 on consecutive cycles, in_ready continuously 1.
- Assert rst for 1 cycle after 2 beats of a 3-beat frame -> no output; the next frame 8'h0F, 8'h33, 8'h55 yields 8'h69. For random sharings, the recombined share-XOR of out_data equals the XOR of the recombined inputs.
